dmem_axil_write_slave: RTL and testbench

// AXI4-Lite write responder on the data-memory side of the store path. Accepts
// AW and W beats independently and buffers one of each. Issues one byte-enabled

---
 rtl/dmem_axil_write_slave_if.sv | 28 ++
 rtl/dmem_axil_write_slave.sv | 187 ++++++++++++++++++
 tb/tb_dmem_axil_write_slave.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_axil_write_slave_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the store initiator and
// the data-memory write responder. No read channels are carried here.
interface dmem_axil_write_slave_if #(
    parameter int XLEN = 32
);
    logic              awvalid;
    logic              awready;
    logic [XLEN-1:0]   awaddr;
    logic              wvalid;
    logic              wready;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    // Store initiator side
    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    // Memory responder side
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/dmem_axil_write_slave.sv
// AXI4-Lite write responder for the data SRAM. AW and W beats are buffered
// independently (one of each); once both are held and no response is
// outstanding, a single byte-enabled word write is issued to the SRAM port
// and a B response is raised. Out-of-window or misaligned addresses get
// SLVERR and never reach the SRAM.
module dmem_axil_write_slave #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    dmem_axil_write_slave_if.slave         s,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_waddr,
    output logic [XLEN-1:0]                mem_wdata,
    output logic [XLEN/8-1:0]              mem_wbe
);

    localparam int NB = XLEN / 8;
    localparam int WA = $clog2(DEPTH_WORDS);
    // Byte span of the memory window, one bit wider so the compare cannot wrap
    localparam logic [XLEN:0] SPAN = (XLEN + 1)'(DEPTH_WORDS) << 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t          state_reg;

    // Holding registers and their occupancy flags
    logic            aw_full_reg;
    logic            aw_full_next;
    logic            w_full_reg;
    logic            w_full_next;
    logic            awready_reg;
    logic            wready_reg;
    logic [XLEN-1:0] awaddr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [NB-1:0]   wstrb_reg;

    // Registered response / SRAM port
    logic            bvalid_reg;
    logic [1:0]      bresp_reg;
    logic            mem_we_reg;
    logic [WA-1:0]   mem_waddr_reg;
    logic [XLEN-1:0] mem_wdata_reg;
    logic [NB-1:0]   mem_wbe_reg;

    logic            aw_take;
    logic            w_take;
    logic            issue;

    // Address decode of the buffered beat
    logic [XLEN-1:0] off;
    logic            addr_below;
    logic            addr_beyond;
    logic            addr_misal;
    logic            err;
    logic [NB-1:0]   lane_we;
    logic            wr_en;

    // Ready comes straight from a register, so valid never feeds ready
    assign aw_take = s.awvalid & awready_reg;
    assign w_take  = s.wvalid & wready_reg;
    // Both beats present and no response pending: this edge is an issue edge
    assign issue   = (state_reg == ST_IDLE) & aw_full_reg & w_full_reg;

    assign off         = awaddr_reg - BASE_ADDR;
    assign addr_below  = awaddr_reg < BASE_ADDR;
    assign addr_beyond = {1'b0, off} >= SPAN;
    assign addr_misal  = awaddr_reg[1:0] != 2'b00;
    assign err         = addr_below | addr_beyond | addr_misal;

    // Per-lane write enable: a lane writes only if strobed and the address decoded
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_we[gi] = wstrb_reg[gi] & ~err;
        end
    endgenerate

    // An all-zero strobe is a legal no-op write: OKAY but no SRAM pulse
    assign wr_en = |lane_we;

    // Next occupancy: an issue drains both slots; a fill only lands in an empty slot
    always_comb begin
        aw_full_next = aw_full_reg;
        w_full_next  = w_full_reg;
        if (issue) begin
            aw_full_next = 1'b0;
            w_full_next  = 1'b0;
        end
        if (aw_take) begin
            aw_full_next = 1'b1;
        end
        if (w_take) begin
            w_full_next = 1'b1;
        end
    end

    // Occupancy flags and registered readies (readies held low through reset)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
        end else begin
            aw_full_reg <= aw_full_next;
            w_full_reg  <= w_full_next;
            awready_reg <= ~aw_full_next;
            wready_reg  <= ~w_full_next;
        end
    end

    // Capture the AW payload when the address slot is filled
    always_ff @(posedge clk) begin
        if (!rstn) begin
            awaddr_reg <= '0;
        end else if (aw_take) begin
            awaddr_reg <= s.awaddr;
        end
    end

    // Capture the W payload when the data slot is filled
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else if (w_take) begin
            wdata_reg <= s.wdata;
            wstrb_reg <= s.wstrb;
        end
    end

    // Issue/response FSM: drives the one-cycle SRAM write and holds B until taken
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= RESP_OKAY;
            mem_we_reg    <= 1'b0;
            mem_waddr_reg <= '0;
            mem_wdata_reg <= '0;
            mem_wbe_reg   <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (aw_full_reg && w_full_reg) begin
                        mem_we_reg    <= wr_en;
                        mem_waddr_reg <= off[2 +: WA];
                        mem_wdata_reg <= wdata_reg;
                        mem_wbe_reg   <= wstrb_reg;
                        bresp_reg     <= err ? RESP_SLVERR : RESP_OKAY;
                        bvalid_reg    <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bvalid_reg && s.bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.awready = awready_reg;
    assign s.wready  = wready_reg;
    assign s.bvalid  = bvalid_reg;
    assign s.bresp   = bresp_reg;
    assign mem_we    = mem_we_reg;
    assign mem_waddr = mem_waddr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wbe   = mem_wbe_reg;

endmodule

// File: tb/tb_dmem_axil_write_slave.sv
// Bench for dmem_axil_write_slave: directed vector table, hand sequences for
// backpressure and mid-response reset, and randomized AW/W/B traffic checked
// against a transaction-level model (beat queues paired in order).
module tb_dmem_axil_write_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk;
    logic        rstn;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;

    dmem_axil_write_slave_if #(.XLEN(32)) ifc ();

    dmem_axil_write_slave #(
        .XLEN        (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s         (ifc),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wbe   (mem_wbe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       we;
        logic [9:0] waddr;
        logic [31:0] wdata;
        logic [3:0] wbe;
        logic [1:0] bresp;
    } txn_t;

    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    txn_t        exp_q[$];

    function automatic txn_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] strb);
        txn_t   t;
        longint a    = longint'(addr);
        longint base = longint'(BASE);
        longint off  = a - base;
        bit     err  = (a < base) || (off >= 4 * DEPTH) || (a % 4 != 0);
        t.we    = !err && (strb != 4'h0);
        t.waddr = 10'(off / 4);
        t.wdata = data;
        t.wbe   = strb;
        t.bresp = err ? 2'b10 : 2'b00;
        return t;
    endfunction

    bit          rst_prev   = 1'b1;
    logic        bv_prev    = 1'b0;
    logic        bhs_prev   = 1'b0;
    logic [1:0]  bresp_prev = 2'b00;

    // Monitor: outputs seen at negedge are the result of the previous posedge;
    // valid/ready seen at negedge are what the next posedge will act on.
    always @(negedge clk) begin
        txn_t        t;
        logic [35:0] wb;
        logic [31:0] ab;
        if (rst_prev) begin
            chk("rst_awready", ifc.awready, 0);
            chk("rst_wready", ifc.wready, 0);
            chk("rst_bvalid", ifc.bvalid, 0);
            chk("rst_bresp", ifc.bresp, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_waddr", mem_waddr, 0);
        end else begin
            if (ifc.bvalid && !bv_prev) begin
                if (exp_q.size() == 0) begin
                    chk("issue_without_beats", ifc.bvalid, 0);
                end else begin
                    t = exp_q[0];
                    chk("issue_mem_we", mem_we, t.we);
                    chk("issue_bresp", ifc.bresp, t.bresp);
                    if (t.we) begin
                        chk("issue_waddr", mem_waddr, t.waddr);
                        chk("issue_wdata", mem_wdata, t.wdata);
                        chk("issue_wbe", mem_wbe, t.wbe);
                    end
                end
            end else begin
                chk("mem_we_outside_issue", mem_we, 0);
            end
            if (bv_prev && !bhs_prev) begin
                chk("bvalid_hold", ifc.bvalid, 1);
                chk("bresp_hold", ifc.bresp, bresp_prev);
            end
        end

        if (!rstn) begin
            aw_q.delete();
            w_q.delete();
            exp_q.delete();
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (ifc.bvalid && ifc.bready && exp_q.size() > 0) begin
                t = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: bresp=%0d we=%0d waddr=%0d wbe=%h", n_txn, t.bresp, t.we, t.waddr, t.wbe);
            end
            if (ifc.awvalid && ifc.awready) aw_q.push_back(ifc.awaddr);
            if (ifc.wvalid && ifc.wready) w_q.push_back({ifc.wstrb, ifc.wdata});
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                ab = aw_q.pop_front();
                wb = w_q.pop_front();
                exp_q.push_back(model(ab, wb[31:0], wb[35:32]));
            end
        end
        bv_prev    = ifc.bvalid;
        bhs_prev   = ifc.bvalid && ifc.bready;
        bresp_prev = ifc.bresp;
    end

    // ---------------- drivers (entered at posedge + 1) ----------------
    task automatic send_aw(input logic [31:0] addr, input int dly, output int hs_cyc, output bit to);
        repeat (dly) @(posedge clk);
        if (dly > 0) #1;
        ifc.awvalid = 1'b1;
        ifc.awaddr  = addr;
        to = 1'b1;
        hs_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc.awready) begin
                hs_cyc = cyc;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifc.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly,
                          output int hs_cyc, output bit to);
        repeat (dly) @(posedge clk);
        if (dly > 0) #1;
        ifc.wvalid = 1'b1;
        ifc.wdata  = data;
        ifc.wstrb  = strb;
        to = 1'b1;
        hs_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc.wready) begin
                hs_cyc = cyc;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifc.wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            output int n_we, output logic [9:0] waddr, output logic [31:0] wdata,
                            output logic [3:0] wbe, output logic [1:0] bresp, output int lat,
                            output bit to);
        int ca, cw, last;
        bit ta, tw;
        n_we = 0; waddr = '0; wdata = '0; wbe = '0; bresp = 2'b11; lat = -1; to = 1'b1;
        ifc.bready = 1'b1;
        fork
            send_aw(addr, aw_dly, ca, ta);
            send_w(data, strb, w_dly, cw, tw);
        join
        last = (ca > cw) ? ca : cw;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we) begin
                n_we++;
                waddr = mem_waddr;
                wdata = mem_wdata;
                wbe   = mem_wbe;
            end
            if (ifc.bvalid) begin
                lat   = cyc - last;
                bresp = ifc.bresp;
                to    = 1'b0;
                break;
            end
        end
        to = to | ta | tw;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int          k = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, DEPTH - 1)) << 2;
        case (k)
            0:       return BASE - 32'(4 * $urandom_range(1, 16));
            1:       return BASE + 32'(4 * DEPTH) + w;
            2:       return BASE + w + 32'($urandom_range(1, 3));
            default: return BASE + w;
        endcase
    endfunction

    task automatic rnd_aw_stream(input int n);
        int c;
        bit t;
        for (int i = 0; i < n; i++) begin
            send_aw(rnd_addr(), $urandom_range(0, 3), c, t);
            chk("rnd_aw_timeout", t, 0);
        end
    endtask

    task automatic rnd_w_stream(input int n);
        int c;
        bit t;
        for (int i = 0; i < n; i++) begin
            send_w($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), c, t);
            chk("rnd_w_timeout", t, 0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          exp_nwe;
        logic [9:0]  exp_waddr;
        logic [1:0]  exp_bresp;
    } vec_t;

    vec_t vecs[9];

    bit rand_on;

    initial begin
        int          n_we, lat, ca, cw, got;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [1:0]  bresp;
        bit          to, ta, tw;

        vecs[0] = '{BASE + 32'h10,   32'hDEAD_BEEF, 4'hF,    0, 0, 1, 10'd4,    2'b00};
        vecs[1] = '{BASE + 32'h40,   32'h00AB_0000, 4'b0100, 0, 3, 1, 10'd16,   2'b00};
        vecs[2] = '{BASE + 32'h40,   32'h00AB_0000, 4'b0100, 2, 0, 1, 10'd16,   2'b00};
        vecs[3] = '{BASE + 32'h1000, 32'h1234_5678, 4'hF,    0, 0, 0, 10'd0,    2'b10};
        vecs[4] = '{BASE + 32'h2,    32'h1234_5678, 4'hF,    0, 0, 0, 10'd0,    2'b10};
        vecs[5] = '{BASE - 32'h4,    32'hCAFE_F00D, 4'hF,    1, 0, 0, 10'd0,    2'b10};
        vecs[6] = '{BASE + 32'hFFC,  32'hA5A5_5A5A, 4'b0011, 0, 1, 1, 10'd1023, 2'b00};
        vecs[7] = '{BASE + 32'h8,    32'hFFFF_FFFF, 4'h0,    0, 0, 0, 10'd0,    2'b00};
        vecs[8] = '{32'hFFFF_FFFC,   32'h0BAD_0BAD, 4'hF,    0, 0, 0, 10'd0,    2'b10};

        rstn        = 1'b0;
        ifc.awvalid = 1'b0;
        ifc.awaddr  = '0;
        ifc.wvalid  = 1'b0;
        ifc.wdata   = '0;
        ifc.wstrb   = '0;
        ifc.bready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_awready", ifc.awready, 1);
        chk("post_rst_wready", ifc.wready, 1);
        @(posedge clk);
        #1;

        // Table-driven single writes from idle
        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly,
                     n_we, waddr, wdata, wbe, bresp, lat, to);
            $display("vec %0d: addr=%h strb=%h bresp=%0d writes=%0d latency=%0d",
                     i, vecs[i].addr, vecs[i].strb, bresp, n_we, lat);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_nwe", i), n_we, vecs[i].exp_nwe);
            chk($sformatf("v%0d_bresp", i), bresp, vecs[i].exp_bresp);
            chk($sformatf("v%0d_latency", i), lat, 2);
            if (vecs[i].exp_nwe != 0) begin
                chk($sformatf("v%0d_waddr", i), waddr, vecs[i].exp_waddr);
                chk($sformatf("v%0d_wdata", i), wdata, vecs[i].data);
                chk($sformatf("v%0d_wbe", i), wbe, vecs[i].strb);
            end
        end

        // W first, then AW two cycles later; W slot stays closed meanwhile
        ifc.bready = 1'b1;
        send_w(32'h00AB_0000, 4'b0100, 0, cw, tw);
        repeat (2) begin
            @(negedge clk);
            chk("wfirst_wready_low", ifc.wready, 0);
            chk("wfirst_no_we", mem_we, 0);
        end
        @(posedge clk);
        #1;
        send_aw(BASE + 32'h40, 0, ca, ta);
        chk("wfirst_timeout", ta | tw, 0);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.bvalid) begin
                chk("wfirst_we", mem_we, 1);
                chk("wfirst_waddr", mem_waddr, 16);
                chk("wfirst_wbe", mem_wbe, 4'b0100);
                chk("wfirst_bresp", ifc.bresp, 0);
                got = 1;
                break;
            end
        end
        chk("wfirst_issue_seen", got, 1);
        @(posedge clk);
        #1;

        // Backpressure: B stalled, second write buffered, slots then closed
        ifc.bready = 1'b0;
        fork
            send_aw(BASE + 32'h100, 0, ca, ta);
            send_w(32'h1111_1111, 4'hF, 0, cw, tw);
        join
        fork
            send_aw(BASE + 32'h104, 0, ca, ta);
            send_w(32'h2222_2222, 4'hC, 0, cw, tw);
        join
        chk("bp_second_accept_timeout", ta | tw, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_awready_low", ifc.awready, 0);
            chk("bp_wready_low", ifc.wready, 0);
            chk("bp_bvalid", ifc.bvalid, 1);
            chk("bp_bresp", ifc.bresp, 0);
        end
        @(posedge clk);
        #1 ifc.bready = 1'b1;
        @(negedge clk);
        chk("bp_first_b_offered", ifc.bvalid, 1);
        @(negedge clk);
        chk("bp_gap_bvalid", ifc.bvalid, 0);
        chk("bp_gap_we", mem_we, 0);
        @(negedge clk);
        chk("bp_second_bvalid", ifc.bvalid, 1);
        chk("bp_second_we", mem_we, 1);
        chk("bp_second_waddr", mem_waddr, 10'h41);
        chk("bp_second_wdata", mem_wdata, 32'h2222_2222);
        chk("bp_second_wbe", mem_wbe, 4'hC);
        @(posedge clk);
        #1;

        // Reset while a response is held and a new AW is buffered
        ifc.bready = 1'b0;
        fork
            send_aw(BASE + 32'h200, 0, ca, ta);
            send_w(32'h4444_4444, 4'hF, 0, cw, tw);
        join
        send_aw(BASE + 32'h204, 0, ca, ta);
        chk("rst_mid_aw_timeout", ta, 0);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_bvalid", ifc.bvalid, 0);
        chk("rst_mid_we", mem_we, 0);
        ifc.bready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_bvalid", ifc.bvalid, 0);
            chk("rst_mid_no_we", mem_we, 0);
        end
        @(posedge clk);
        #1;
        do_write(BASE + 32'h208, 32'h5566_7788, 4'hF, 0, 0, n_we, waddr, wdata, wbe, bresp, lat, to);
        $display("post-reset write: bresp=%0d writes=%0d waddr=%0d", bresp, n_we, waddr);
        chk("rst_fresh_timeout", to, 0);
        chk("rst_fresh_nwe", n_we, 1);
        chk("rst_fresh_waddr", waddr, 10'h82);
        chk("rst_fresh_wdata", wdata, 32'h5566_7788);
        chk("rst_fresh_bresp", bresp, 0);

        // Randomized independent AW/W streams with random B backpressure
        rand_on = 1'b1;
        fork
            begin
                fork
                    rnd_aw_stream(60);
                    rnd_w_stream(60);
                join
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1 ifc.bready = 1'($urandom_range(0, 1));
                end
            end
        join
        ifc.bready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0) break;
        end
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_aw_q", aw_q.size(), 0);
        chk("drain_w_q", w_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
